// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully connected layer: one signed MAC per cycle over an
// N_OUT x N_IN weight memory, streaming inputs in and quantised neurons out.
`timescale 1ns/1ps
module fc_layer_seq #(
    parameter int N_IN   = 10,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0,
    parameter int RELU   = 1,
    localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int BA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                w_we,
    input  logic [WA_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                b_we,
    input  logic [BA_W-1:0]     b_addr,
    input  logic [2*DATA_W-1:0] b_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [BA_W-1:0]     out_idx,
    output logic                out_last,
    output logic                busy
);
    localparam int K_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int P_W = 2 * DATA_W + 1;

    if (ACC_W < 2 * DATA_W + $clog2(N_IN) + 2) begin : g_acc_chk
        $error("fc_layer_seq: ACC_W too narrow for DATA_W/N_IN");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_shift_chk
        $error("fc_layer_seq: SHIFT out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_e;

    state_e                    state_q, state_d;
    logic [K_W-1:0]            in_cnt_q, in_cnt_d, k_q, k_d;
    logic [BA_W-1:0]           neuron_q, neuron_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      in_ready_q, in_ready_d, busy_q, busy_d;
    logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic [BA_W-1:0]           out_idx_q, out_idx_d;

    logic signed [DATA_W-1:0]   w_mem_q [N_IN*N_OUT];
    logic signed [2*DATA_W-1:0] b_mem_q [N_OUT];
    logic [DATA_W-1:0]          x_q     [N_IN];

    logic                      accept;
    logic [WA_W-1:0]           w_idx;
    logic signed [DATA_W-1:0]  w_cur;
    logic signed [2*DATA_W-1:0] b_cur;
    logic signed [P_W-1:0]     xs, ws, prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext;

    assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
    assign w_idx    = WA_W'(neuron_q) * WA_W'(N_IN) + WA_W'(k_q);
    assign w_cur    = w_mem_q[w_idx];
    assign b_cur    = b_mem_q[neuron_q];
    // Activation is unsigned: zero-extend it so the signed multiply stays exact.
    assign xs       = {{(P_W-DATA_W){1'b0}}, x_q[k_q]};
    assign ws       = {{(P_W-DATA_W){w_cur[DATA_W-1]}}, w_cur};
    assign prod     = xs * ws;
    assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-2*DATA_W){b_cur[2*DATA_W-1]}}, b_cur};

    function automatic logic [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s, hi, lo;
        s = a >>> SHIFT;
        if (RELU != 0) begin
            hi = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
            lo = '0;
        end else begin
            hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
            lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        end
        if (s < lo)      quant = lo[DATA_W-1:0];
        else if (s > hi) quant = hi[DATA_W-1:0];
        else             quant = s[DATA_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        k_d         = k_q;
        neuron_d    = neuron_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_cnt_q == K_W'(N_IN - 1)) begin
                        in_cnt_d = '0;
                        k_d      = '0;
                        neuron_d = '0;
                        state_d  = S_MAC;
                    end else begin
                        in_cnt_d = in_cnt_q + K_W'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = ((k_q == '0) ? bias_ext : acc_q) + prod_ext;
                if (k_q == K_W'(N_IN - 1)) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = quant(acc_d);
                    out_idx_d   = neuron_q;
                    out_last_d  = (neuron_q == BA_W'(N_OUT - 1));
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        neuron_d = neuron_q + BA_W'(1);
                        k_d      = '0;
                        state_d  = S_MAC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            k_q         <= '0;
            neuron_q    <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            k_q         <= k_d;
            neuron_q    <= neuron_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_IN * N_OUT; i++) w_mem_q[i] <= '0;
            for (int unsigned i = 0; i < N_OUT; i++)        b_mem_q[i] <= '0;
            for (int unsigned i = 0; i < N_IN; i++)         x_q[i]     <= '0;
        end else begin
            if (w_we && !busy_q) w_mem_q[w_addr] <= w_data;
            if (b_we && !busy_q) b_mem_q[b_addr] <= b_data;
            if (accept)          x_q[in_cnt_q]   <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: default, RELU=0 and SHIFT=4 builds run in
// lockstep on shared stimulus, each checked against hand-computed values.
`timescale 1ns/1ps
module tb_fc_layer_seq;
    logic        clk, reset_n;
    logic        w_we, b_we, in_valid, out_ready;
    logic [6:0]  w_addr;
    logic [7:0]  w_data, in_data;
    logic [3:0]  b_addr;
    logic [15:0] b_data;

    logic       in_ready, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic [3:0] out_idx;
    logic       in_ready_n, out_valid_n, out_last_n, busy_n;
    logic [7:0] out_data_n;
    logic [3:0] out_idx_n;
    logic       in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [7:0] out_data_s;
    logic [3:0] out_idx_s;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int c_acc, f_c, l_c, g;

    logic [7:0] xv [10];
    logic [7:0] exp_d [10];
    logic [7:0] exp_n [10];
    logic [7:0] exp_s [10];

    fc_layer_seq u_dut (
        .clk(clk), .reset_n(reset_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy));

    fc_layer_seq #(.RELU(0)) u_nr (
        .clk(clk), .reset_n(reset_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .in_valid(in_valid),
        .in_ready(in_ready_n), .in_data(in_data), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .out_idx(out_idx_n),
        .out_last(out_last_n), .busy(busy_n));

    fc_layer_seq #(.SHIFT(4)) u_sh (
        .clk(clk), .reset_n(reset_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_idx(out_idx_s),
        .out_last(out_last_s), .busy(busy_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_data"},  32'(out_data), 0);
        chk({tag, " out_idx"},   32'(out_idx), 0);
        chk({tag, " out_last"},  32'(out_last), 0);
        chk({tag, " busy"},      32'(busy), 0);
        chk({tag, " in_ready"},  32'(in_ready), 0);
        chk({tag, " nr outs"},   32'({out_valid_n, out_data_n, out_idx_n, out_last_n, busy_n, in_ready_n}), 0);
        chk({tag, " sh outs"},   32'({out_valid_s, out_data_s, out_idx_s, out_last_s, busy_s, in_ready_s}), 0);
    endtask

    task automatic wr_w(input int a, input int d);
        w_we = 1'b1; w_addr = 7'(a); w_data = 8'(d);
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic wr_b(input int a, input int d);
        b_we = 1'b1; b_addr = 4'(a); b_data = 16'(d);
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    task automatic load_shift_cfg();
        for (int n = 0; n < 10; n++)
            for (int i = 0; i < 10; i++) wr_w(n * 10 + i, (n == i) ? 16 : 0);
        for (int i = 0; i < 10; i++) wr_b(i, 8);
    endtask

    task automatic send(output int acc_c);
        int gw = 0;
        while (!in_ready && gw < 100) begin @(posedge clk); #1; gw++; end
        chk("in_ready before send", 32'(in_ready), 1);
        for (int j = 0; j < 10; j++) begin
            in_valid = 1'b1; in_data = xv[j];
            @(posedge clk); #1;
            w_we = 1'b0; b_we = 1'b0;
        end
        in_valid = 1'b0;
        acc_c = cyc;
        chk("in_ready after last beat", 32'(in_ready), 0);
        chk("busy after last beat", 32'(busy), 1);
    endtask

    task automatic collect(input int stall_idx, input int stall_cyc, output int first_c, output int last_c);
        int n = 0;
        int guard = 0;
        first_c = -1; last_c = -1;
        while (n < 10 && guard < 3000) begin
            if (out_valid) begin
                if (first_c < 0) first_c = cyc;
                if (n == stall_idx) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < stall_cyc; s++) begin
                        @(posedge clk); #1;
                        chk("stall out_valid", 32'(out_valid), 1);
                        chk("stall out_idx", 32'(out_idx), 32'(n));
                        chk("stall out_data", 32'(out_data), 32'(exp_d[n]));
                        chk("stall in_ready", 32'(in_ready), 0);
                    end
                    out_ready = 1'b1;
                end
                chk($sformatf("out_idx@%0d", n), 32'(out_idx), 32'(n));
                chk($sformatf("out_last@%0d", n), 32'(out_last), 32'(n == 9));
                chk($sformatf("lockstep valid@%0d", n), 32'({out_valid_n, out_valid_s}), 3);
                chk($sformatf("out_data@%0d", n), 32'(out_data), 32'(exp_d[n]));
                chk($sformatf("nr out_data@%0d", n), 32'(out_data_n), 32'(exp_n[n]));
                chk($sformatf("sh out_data@%0d", n), 32'(out_data_s), 32'(exp_s[n]));
                last_c = cyc;
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        chk("outputs received", 32'(n), 10);
        chk("in_ready after out_last", 32'(in_ready), 1);
        chk("busy after out_last", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; w_we = 1'b0; b_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_addr = '0; w_data = '0; b_addr = '0; b_data = '0; in_data = '0;
        #12;
        chk_zero("reset");
        @(negedge clk); reset_n = 1'b1;
        #1 chk("in_ready before first edge", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready after first edge", 32'(in_ready), 1);

        // Basic MAC: all weights 1, inputs 10 -> 100 (SHIFT=4 build: 6)
        for (int a = 0; a < 100; a++) wr_w(a, 1);
        for (int j = 0; j < 10; j++) begin
            xv[j] = 8'd10; exp_d[j] = 8'd100; exp_n[j] = 8'd100; exp_s[j] = 8'd6;
        end
        send(c_acc);
        collect(-1, 0, f_c, l_c);
        chk("first out_valid latency", 32'(f_c - c_acc), 10);
        chk("last out_valid latency", 32'(l_c - c_acc), 109);

        // Backpressure at idx 3 for 5 cycles
        send(c_acc);
        collect(3, 5, f_c, l_c);
        chk("stalled last latency", 32'(l_c - c_acc), 114);

        // Weight write while busy is dropped
        send(c_acc);
        w_we = 1'b1; w_addr = 7'd0; w_data = 8'd50;
        @(posedge clk); #1;
        w_we = 1'b0;
        collect(-1, 0, f_c, l_c);

        // Same write in IDLE, coinciding with the first input beat
        w_we = 1'b1; w_addr = 7'd0; w_data = 8'd50;
        exp_d[0] = 8'd255; exp_n[0] = 8'd127; exp_s[0] = 8'd36;
        send(c_acc);
        collect(-1, 0, f_c, l_c);

        // ReLU / saturation; last weight written together with bias[2]=-5
        for (int a = 0; a < 99; a++) wr_w(a, (a < 10) ? -1 : ((a < 20) ? 127 : 0));
        w_we = 1'b1; w_addr = 7'd99; w_data = 8'd0;
        b_we = 1'b1; b_addr = 4'd2; b_data = 16'hFFFB;
        @(posedge clk); #1;
        w_we = 1'b0; b_we = 1'b0;
        for (int j = 0; j < 10; j++) begin
            xv[j] = 8'd255; exp_d[j] = 8'd0; exp_n[j] = 8'd0; exp_s[j] = 8'd0;
        end
        exp_d[1] = 8'd255; exp_n[0] = 8'h80; exp_n[1] = 8'd127; exp_n[2] = 8'hFB;
        exp_s[1] = 8'd255;
        send(c_acc);
        collect(-1, 0, f_c, l_c);

        // Shift: diagonal 16, bias 8, x[j]=10j -> acc=160i+8
        load_shift_cfg();
        for (int j = 0; j < 10; j++) begin
            xv[j] = 8'(10 * j); exp_s[j] = 8'(10 * j);
            exp_d[j] = (j == 0) ? 8'd8 : ((j == 1) ? 8'd168 : 8'd255);
            exp_n[j] = (j == 0) ? 8'd8 : 8'd127;
        end
        send(c_acc);
        collect(-1, 0, f_c, l_c);

        // Reset during MAC of neuron 4
        send(c_acc);
        g = 0;
        while (!(out_valid && out_idx == 4'd3) && g < 500) begin @(posedge clk); #1; g++; end
        chk("reached idx 3", 32'(out_idx), 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid-MAC busy", 32'(busy), 1);
        chk("mid-MAC out_valid", 32'(out_valid), 0);
        #2 reset_n = 1'b0;
        #1 chk_zero("async reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        #1 chk("in_ready held after reset", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready back after reset", 32'(in_ready), 1);

        // Memories cleared: no reload gives all zeros
        for (int j = 0; j < 10; j++) begin exp_d[j] = '0; exp_n[j] = '0; exp_s[j] = '0; end
        send(c_acc);
        collect(-1, 0, f_c, l_c);

        // Reload and resend
        load_shift_cfg();
        for (int j = 0; j < 10; j++) begin
            exp_s[j] = 8'(10 * j);
            exp_d[j] = (j == 0) ? 8'd8 : ((j == 1) ? 8'd168 : 8'd255);
            exp_n[j] = (j == 0) ? 8'd8 : 8'd127;
        end
        send(c_acc);
        collect(-1, 0, f_c, l_c);
        chk("reload first latency", 32'(f_c - c_acc), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
